// File: rtl/aibio_hvmadc_seqctl.sv
// aibio_hvmadc_seqctl -- scan sequencer for the HV monitor ADC.
//
// Walks the 8-input analog mux over a latched channel mask, pulses the ADC
// start, waits for conversion-done (resynchronised), stores a 10-bit result
// per channel and flags over-threshold results and conversion timeouts.
//
// Ports:
//   adcclk, reset        clock (ADC domain), synchronous active-high reset
//   scan_en, single_shot continuous-scan level / one-pass request pulse
//   ch_mask              channel enable mask, latched at the start of each pass
//   hi_thresh            alarm threshold (result > hi_thresh alarms)
//   clr                  clears alarm and timeout_err (a same-cycle set wins)
//   adcdone, adcout      ADC conversion done (asynchronous) and result
//   adc_en, adc_anamux_sel, adc_start   registered ADC controls
//   rd_ch, rd_data       combinational result readback
//   rd_valid, alarm      per-channel result-valid / sticky over-threshold flags
//   timeout_err          sticky conversion timeout
//   busy, scan_done      sequencer active / one-cycle end-of-pass pulse
module aibio_hvmadc_seqctl #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       adcclk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic       single_shot,
  input  logic [7:0] ch_mask,
  input  logic [9:0] hi_thresh,
  input  logic       clr,
  input  logic       adcdone,
  input  logic [9:0] adcout,
  output logic       adc_en,
  output logic [2:0] adc_anamux_sel,
  output logic       adc_start,
  input  logic [2:0] rd_ch,
  output logic [9:0] rd_data,
  output logic [7:0] rd_valid,
  output logic [7:0] alarm,
  output logic       timeout_err,
  output logic       busy,
  output logic       scan_done
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES
                                                                     : SETTLE_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    WAIT,
    CAPTURE
  } state_e;

  state_e        state_q;
  logic [7:0]    pass_mask_q;
  logic          cont_q;
  logic [2:0]    ch_q;
  logic [CW-1:0] cnt_q;
  logic          abort_q;
  logic          adc_en_q;
  logic [2:0]    sel_q;
  logic          start_q;
  logic          busy_q;
  logic          scan_done_q;
  logic [7:0]    alarm_q;
  logic          tout_q;
  logic [7:0]    rd_valid_q;
  logic [9:0]    res_q [8];

  // adcdone resynchroniser and rising-edge detect
  logic [1:0] sync_q;
  logic       done_prev_q;
  logic       done_rise;

  always_ff @(posedge adcclk) begin
    if (reset) begin
      sync_q      <= '0;
      done_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], adcdone};
      done_prev_q <= sync_q[1];
    end
  end

  assign done_rise = sync_q[1] & ~done_prev_q;

  // Lowest set bit of the live mask (used when a pass is latched)
  logic [2:0] first_ch;
  logic       mask_nz;

  always_comb begin
    first_ch = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (ch_mask[i-1]) first_ch = 3'(i - 1);
    end
  end

  assign mask_nz = |ch_mask;

  // Next higher set bit of the latched pass mask above the current channel
  logic [2:0] nxt_ch;
  logic       nxt_vld;

  always_comb begin
    nxt_ch  = '0;
    nxt_vld = 1'b0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (pass_mask_q[i-1] && ((i - 1) > 32'(ch_q))) begin
        nxt_ch  = 3'(i - 1);
        nxt_vld = 1'b1;
      end
    end
  end

  logic over_thresh;
  assign over_thresh = adcout > hi_thresh;

  always_ff @(posedge adcclk) begin
    if (reset) begin
      state_q     <= IDLE;
      pass_mask_q <= '0;
      cont_q      <= 1'b0;
      ch_q        <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      adc_en_q    <= 1'b0;
      sel_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      alarm_q     <= '0;
      tout_q      <= 1'b0;
      rd_valid_q  <= '0;
      for (int unsigned i = 0; i < 8; i++) res_q[i] <= '0;
    end else begin
      start_q     <= 1'b0;
      scan_done_q <= 1'b0;

      // Clear first; set assignments below override it within the same cycle
      if (clr) begin
        alarm_q <= '0;
        tout_q  <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if ((scan_en || single_shot) && mask_nz) begin
            pass_mask_q <= ch_mask;
            cont_q      <= scan_en;
            ch_q        <= first_ch;
            sel_q       <= first_ch;
            cnt_q       <= '0;
            adc_en_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SELECT;
          end
        end

        SELECT: begin
          if (cnt_q == SETTLE_LAST) begin
            start_q <= 1'b1;
            state_q <= START;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end

        WAIT: begin
          if (done_rise) begin
            abort_q     <= 1'b0;
            scan_done_q <= ~nxt_vld;
            state_q     <= CAPTURE;
          end else if (cnt_q == TIMEOUT_CNT) begin
            // Timeout reuses the CAPTURE cycle (without a write) so pass-end
            // handling and scan_done timing match the normal capture path.
            tout_q           <= 1'b1;
            rd_valid_q[ch_q] <= 1'b0;
            abort_q          <= 1'b1;
            scan_done_q      <= ~nxt_vld;
            state_q          <= CAPTURE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        CAPTURE: begin
          if (!abort_q) begin
            res_q[ch_q]      <= adcout;
            rd_valid_q[ch_q] <= 1'b1;
            if (over_thresh) alarm_q[ch_q] <= 1'b1;
          end
          cnt_q <= '0;
          if (nxt_vld) begin
            ch_q    <= nxt_ch;
            sel_q   <= nxt_ch;
            state_q <= SELECT;
          end else if (cont_q && scan_en && mask_nz) begin
            pass_mask_q <= ch_mask;
            ch_q        <= first_ch;
            sel_q       <= first_ch;
            state_q     <= SELECT;
          end else begin
            adc_en_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign adc_en         = adc_en_q;
  assign adc_anamux_sel = sel_q;
  assign adc_start      = start_q;
  assign busy           = busy_q;
  assign scan_done      = scan_done_q;
  assign alarm          = alarm_q;
  assign timeout_err    = tout_q;
  assign rd_valid       = rd_valid_q;
  assign rd_data        = res_q[rd_ch];

endmodule

// File: tb/tb_aibio_hvmadc_seqctl.sv
`timescale 1ns/1ps
module tb_aibio_hvmadc_seqctl;

  localparam int unsigned SETTLE = 16;
  localparam int unsigned TMO    = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_en = 1'b0;
  logic       single_shot = 1'b0;
  logic [7:0] ch_mask = '0;
  logic [9:0] hi_thresh = '1;
  logic       clr = 1'b0;
  logic       adcdone = 1'b0;
  logic [9:0] adcout = '0;
  logic       adc_en;
  logic [2:0] adc_anamux_sel;
  logic       adc_start;
  logic [2:0] rd_ch = '0;
  logic [9:0] rd_data;
  logic [7:0] rd_valid;
  logic [7:0] alarm;
  logic       timeout_err;
  logic       busy;
  logic       scan_done;

  always #5 clk = ~clk;

  aibio_hvmadc_seqctl #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .adcclk        (clk),
    .reset         (rst),
    .scan_en       (scan_en),
    .single_shot   (single_shot),
    .ch_mask       (ch_mask),
    .hi_thresh     (hi_thresh),
    .clr           (clr),
    .adcdone       (adcdone),
    .adcout        (adcout),
    .adc_en        (adc_en),
    .adc_anamux_sel(adc_anamux_sel),
    .adc_start     (adc_start),
    .rd_ch         (rd_ch),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .alarm         (alarm),
    .timeout_err   (timeout_err),
    .busy          (busy),
    .scan_done     (scan_done)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  valid;
    logic [7:0]  alarm;
    logic        tout;
    logic [79:0] res;
  } pass_t;

  int unsigned sel_q[$];
  pass_t       pass_q[$];

  logic [7:0] m_valid;
  logic [7:0] m_alarm;
  logic       m_tout;
  logic [9:0] m_res [8];

  // ADC behaviour per channel
  logic [9:0]  val [8];
  bit          noresp [8];
  int unsigned late_delay = 0;

  function automatic void model_reset();
    m_valid = '0;
    m_alarm = '0;
    m_tout  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) m_res[i] = '0;
  endfunction

  function automatic void model_clr();
    m_alarm = '0;
    m_tout  = 1'b0;
  endfunction

  // One pass over mask in ascending channel order; clr_at_end models a clr
  // pulse coinciding with the last channel's capture (its own set survives).
  function automatic void model_pass(input logic [7:0] mask, input bit clr_at_end,
                                     input logic [9:0] th);
    int unsigned last = 0;
    pass_t p;
    for (int unsigned i = 0; i < 8; i++) if (mask[i]) last = i;
    for (int unsigned i = 0; i < 8; i++) begin
      if (mask[i]) begin
        sel_q.push_back(i);
        if (clr_at_end && i == last) model_clr();
        if (noresp[i]) begin
          m_valid[i] = 1'b0;
          m_tout     = 1'b1;
        end else begin
          m_res[i]   = val[i];
          m_valid[i] = 1'b1;
          if (val[i] > th) m_alarm[i] = 1'b1;
        end
      end
    end
    p.valid = m_valid;
    p.alarm = m_alarm;
    p.tout  = m_tout;
    for (int unsigned i = 0; i < 8; i++) p.res[i*10 +: 10] = m_res[i];
    pass_q.push_back(p);
  endfunction

  // ---------------- ADC behavioural model ----------------
  always @(negedge clk) begin
    if (!rst && adc_start) begin
      automatic int unsigned ch = 32'(adc_anamux_sel);
      automatic int unsigned d;
      adcdone = 1'b0;
      if (!noresp[ch]) begin
        d = (late_delay != 0) ? late_delay : $urandom_range(3, 12);
        repeat (d) @(negedge clk);
        adcout  = val[ch];
        adcdone = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int unsigned ncyc = 0;
  int unsigned busy_rise_n = 0;
  int unsigned last_start_n = 0;
  int unsigned start_cnt = 0;
  bit          busy_prev = 0;
  bit          rise_pend = 0;
  bit          tout_prev = 0;
  bit          chk_pend = 0;

  always @(negedge clk) begin
    automatic bit   do_sweep = 0;
    automatic pass_t p;
    ncyc++;
    if (rst) begin
      busy_prev = 0;
      rise_pend = 0;
      tout_prev = 0;
      chk_pend  = 0;
    end else begin
      if (chk_pend) begin
        chk_pend = 0;
        if (pass_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pass_end: got unexpected scan_done expected none");
        end else begin
          p = pass_q.pop_front();
          check("rd_valid", rd_valid, p.valid);
          check("alarm", alarm, p.alarm);
          check("timeout_err", timeout_err, p.tout);
          do_sweep = 1;
        end
      end
      if (busy && !busy_prev) begin
        busy_rise_n = ncyc;
        rise_pend   = 1;
      end
      if (adc_start) begin
        start_cnt++;
        last_start_n = ncyc;
        check("adc_en_at_start", adc_en, 1'b1);
        if (sel_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start: got unexpected adc_start sel=%0d expected none", adc_anamux_sel);
        end else begin
          check("sel", adc_anamux_sel, sel_q.pop_front());
        end
        if (rise_pend) begin
          check("settle_latency", ncyc - busy_rise_n, SETTLE);
          rise_pend = 0;
        end
      end
      if (timeout_err && !tout_prev) check("timeout_latency", ncyc - last_start_n, TMO + 2);
      if (scan_done) chk_pend = 1;
      busy_prev = busy;
      tout_prev = timeout_err;
      if (do_sweep) begin
        for (int unsigned i = 0; i < 8; i++) begin
          rd_ch = 3'(i);
          #0.5;
          check("rd_data", rd_data, p.res[i*10 +: 10]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_single();
    @(negedge clk) single_shot = 1'b1;
    @(negedge clk) single_shot = 1'b0;
  endtask

  task automatic wait_starts(input int unsigned n);
    int unsigned k = 0;
    while (start_cnt < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("wait_start_timeout", (start_cnt >= n), 1'b1);
  endtask

  task automatic wait_idle(input int unsigned limit);
    int unsigned k = 0;
    bit ok = 0;
    while (k < limit) begin
      @(negedge clk);
      k++;
      if (!busy && sel_q.size() == 0 && pass_q.size() == 0 && !chk_pend) begin
        ok = 1;
        break;
      end
    end
    check("wait_idle_timeout", ok, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_adc_en"}, adc_en, 1'b0);
    check({tag, "_sel"}, adc_anamux_sel, 3'd0);
    check({tag, "_start"}, adc_start, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_scan_done"}, scan_done, 1'b0);
    check({tag, "_alarm"}, alarm, 8'h00);
    check({tag, "_tout"}, timeout_err, 1'b0);
    check({tag, "_rd_valid"}, rd_valid, 8'h00);
  endtask

  task automatic rand_vals();
    for (int unsigned i = 0; i < 8; i++) val[i] = 10'($urandom_range(0, 1023));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned base;
    bit          busy_seen;
    for (int unsigned i = 0; i < 8; i++) begin
      val[i]    = '0;
      noresp[i] = 0;
    end
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_rd_data", rd_data, 10'h000);
    rst = 1'b0;

    // single-channel single shot; a repeat request while busy is ignored
    val[0]    = 10'h200;
    hi_thresh = 10'h3FF;
    ch_mask   = 8'h01;
    model_pass(8'h01, 0, hi_thresh);
    base = start_cnt;
    pulse_single();
    wait_starts(base + 1);
    pulse_single();
    wait_idle(2000);

    // sparse continuous scan, scan_en dropped during ch2 of the third pass
    rand_vals();
    hi_thresh = 10'($urandom_range(0, 1023));
    model_pass(8'hA5, 0, hi_thresh);
    model_pass(8'hA5, 0, hi_thresh);
    model_pass(8'hA5, 0, hi_thresh);
    base = start_cnt;
    @(negedge clk);
    ch_mask = 8'hA5;
    scan_en = 1'b1;
    wait_starts(base + 10);
    scan_en = 1'b0;
    wait_idle(5000);

    // threshold boundary, then clr coincident with a new alarm set
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    model_clr();
    hi_thresh = 10'h300;
    val[0]    = 10'h300;
    val[1]    = 10'h301;
    ch_mask   = 8'h03;
    model_pass(8'h03, 0, hi_thresh);
    pulse_single();
    wait_idle(2000);
    val[2]  = 10'h301;
    ch_mask = 8'h04;
    model_pass(8'h04, 1, hi_thresh);
    pulse_single();
    begin
      int unsigned k = 0;
      while (!scan_done && k < 2000) begin
        @(negedge clk);
        k++;
      end
      check("scan_done_seen", scan_done, 1'b1);
    end
    clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    wait_idle(2000);

    // timeout on channel 2, scan continues with channel 3
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    model_clr();
    noresp[2] = 1;
    val[3]    = 10'($urandom_range(0, 1023));
    ch_mask   = 8'h0C;
    model_pass(8'h0C, 0, hi_thresh);
    pulse_single();
    wait_idle(3000);
    noresp[2] = 0;

    // reset while in WAIT; the late adcdone must be ignored
    late_delay = 40;
    ch_mask    = 8'h01;
    sel_q.push_back(0);
    base = start_cnt;
    pulse_single();
    wait_starts(base + 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sel_q.delete();
    pass_q.delete();
    model_reset();
    repeat (60) @(negedge clk);
    check_reset_outputs("post_reset");
    late_delay = 0;

    // empty mask: single_shot is dropped
    ch_mask = 8'h00;
    pulse_single();
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    check("empty_mask_busy", busy_seen, 1'b0);

    // mask change during ch1 takes effect on the next pass only
    rand_vals();
    hi_thresh = 10'($urandom_range(0, 1023));
    model_pass(8'h0F, 0, hi_thresh);
    model_pass(8'hF0, 0, hi_thresh);
    base = start_cnt;
    @(negedge clk);
    ch_mask = 8'h0F;
    scan_en = 1'b1;
    wait_starts(base + 2);
    ch_mask = 8'hF0;
    wait_starts(base + 5);
    scan_en = 1'b0;
    wait_idle(5000);

    // randomized single-shot passes
    for (int unsigned r = 0; r < 4; r++) begin
      logic [7:0] m;
      m = 8'($urandom_range(1, 255));
      rand_vals();
      hi_thresh = 10'($urandom_range(0, 1023));
      ch_mask   = m;
      model_pass(m, 0, hi_thresh);
      pulse_single();
      wait_idle(5000);
    end

    check("sel_queue_drained", sel_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aibio_hvmadc_seqctl.md
# aibio_hvmadc_seqctl

Scan sequencer for the HV monitor ADC. Walks the 8-input analog mux over a programmable channel mask and drives the ADC enable, mux select and start controls. It waits for each conversion-done, stores a per-channel 10-bit result, and flags over-threshold channels and conversion timeouts. It sits between the monitor CSR block and the HV monitor ADC macro, in the ADC clock domain.

## Interface
Parameters:
- SETTLE_CYCLES, 16, mux settling cycles after each select change (≥1)
- TIMEOUT_CYCLES, 20000, max cycles waited in WAIT before abort (covers 1024 conversions at divide-by-16 plus margin)

Ports:
- adcclk  in  1  clock; same clock that feeds the ADC divider
- reset  in  1  synchronous, active-high
- scan_en  in  1  level; continuous scanning while high
- single_shot  in  1  pulse; one full pass over the mask
- ch_mask  in  8  channel enable, bit i = adc_anain[i]
- hi_thresh  in  10  alarm threshold
- clr  in  1  pulse; clears alarm and timeout_err
- adcdone  in  1  ADC conversion done, asynchronous to the FSM
- adcout  in  10  ADC result, stable from adcdone rise until next conversion
- adc_en  out  1  ADC enable
- adc_anamux_sel  out  3  ADC mux select
- adc_start  out  1  conversion start pulse
- rd_ch  in  3  result readback index
- rd_data  out  10  stored result of channel rd_ch (combinational read)
- rd_valid  out  8  per-channel result-valid
- alarm  out  8  sticky, result > hi_thresh
- timeout_err  out  1  sticky conversion timeout
- busy  out  1  FSM not IDLE
- scan_done  out  1  one-cycle pulse at end of each pass

## Operation
- adcdone is resynchronised with a 2-flop synchroniser. done_rise = sync high AND previous sync low.
- States:
  - IDLE: adc_en=0, no start issued.
  - SELECT: drive adc_anamux_sel, count SETTLE_CYCLES.
  - START: adc_start=1 for exactly 1 cycle.
  - WAIT: wait for done_rise while counting for timeout.
  - CAPTURE: 1 cycle, store the result.
- IDLE exit: when (scan_en OR single_shot) and ch_mask≠0. Latch ch_mask into pass_mask and latch the mode (single if scan_en=0). Go to SELECT with the lowest set bit of pass_mask.
- ch_mask=0: stay in IDLE and drop a single_shot request. No outputs change.
- adc_en=1 in every state except IDLE.
- WAIT behaviour:
  - done_rise → CAPTURE.
  - Timeout counter reaches TIMEOUT_CYCLES → set timeout_err, clear rd_valid[ch], go to the next channel without writing the result.
- CAPTURE: result[ch] ← adcout and rd_valid[ch] ← 1. If adcout > hi_thresh (unsigned), set alarm[ch]. Equality does not alarm.
- Next channel: the next higher set bit of pass_mask.
- End of pass (no higher set bit):
  - Pulse scan_done.
  - Continuous mode with scan_en still 1 → re-latch ch_mask and restart at its lowest set bit.
  - Otherwise → IDLE.
- scan_en falling mid-pass: the current pass completes, then IDLE. There is no abort except reset.
- ch_mask changes mid-pass take effect at the next pass only.
- single_shot while busy is ignored.
- clr clears alarm and timeout_err. A set in the same cycle wins over clr.
- Result storage is not cleared by clr. rd_valid persists until reset or a timeout on that channel.

## Timing
- Reset values:
  - adc_en=0, adc_anamux_sel=0, adc_start=0, busy=0, scan_done=0.
  - alarm=0, timeout_err=0, rd_valid=0, all results=0, FSM=IDLE.
- Reset mid-conversion returns everything to reset values on the next edge. A late adcdone then arrives in IDLE and is ignored.
- All control outputs are registered.
- Per-channel sequence from entering SELECT:
  - adc_anamux_sel valid in the first SELECT cycle.
  - adc_start high in cycle SETTLE_CYCLES.
  - WAIT starts the following cycle.
- Latency from adcdone rising (registered at adcclk) to CAPTURE is 3 cycles: 2 sync + edge. rd_valid and alarm update the cycle after CAPTURE.
- Timeout counter resets on WAIT entry. It aborts on the cycle the count equals TIMEOUT_CYCLES.
- scan_done is asserted in the CAPTURE (or timeout) cycle of the last channel.
- busy drops the cycle after scan_done when going to IDLE.
- Back-to-back passes add no extra idle cycles.

## Test plan
- Single-channel single-shot:
  - Stimulus: ch_mask=8'h01, single_shot pulse, SETTLE_CYCLES=16, ADC model returns 10'h200.
  - Required response: sel=0; adc_start one cycle high 16 cycles after busy rises; rd_valid=8'h01; rd_data=10'h200 for rd_ch=0; scan_done once; return to IDLE.
- Sparse-mask continuous scan:
  - Stimulus: ch_mask=8'hA5, scan_en=1.
  - Required response: sel sequence 0,2,5,7,0,2…; scan_done after each ch7 capture; deassert scan_en during ch2 → pass finishes at ch7, then IDLE.
- Threshold boundary:
  - Stimulus: hi_thresh=10'h300; channel results 10'h300 and 10'h301.
  - Required response: alarm only on the 10'h301 channel. clr coincident with a new alarm set → alarm stays set.
- Timeout:
  - Stimulus: adcdone held low, TIMEOUT_CYCLES=100.
  - Required response: abort exactly 100 cycles after WAIT entry; timeout_err=1; rd_valid for that channel cleared; scan continues to the next channel.
- Reset and empty mask:
  - Stimulus: reset asserted during WAIT, then adcdone pulses.
  - Required response: all outputs at reset values and no capture.
  - Stimulus: ch_mask=0 with single_shot.
  - Required response: busy stays 0.
- Mask change mid-pass:
  - Stimulus: ch_mask 8'h0F → 8'hF0 during the ch1 conversion.
  - Required response: channels 2,3 complete, then the next pass scans 4–7.
